// File: rtl/hamming_top.sv
// -----------------------------------------------------------------------------
// hamming_top -- two-stage pipelined SECDED Hamming encoder/decoder.
//
// Stage 1 encodes the K-bit information word into an (N+1)-bit extended
// Hamming codeword (optionally corrupted by an error-injection mask) and
// registers it. Stage 2 computes the syndrome and overall parity of the
// registered codeword, corrects single-bit errors, flags uncorrectable ones
// and registers every output. Latency d_i -> outputs is two rising edges,
// with a new word accepted every cycle.
//
// Codeword layout: cw[1..N] are Hamming positions, with parity bits at the
// power-of-two positions and data bits in the rest (d[0] at the lowest).
// cw[0] is even parity over cw[1..N].
//
// Optional feature macro: HAMMING_ERR_INJ_EN
//   defined   -> err_mask_i port exists and is XORed onto the codeword
//   undefined -> no err_mask_i port; the mask is treated as all-zero
//
// Parameters:
//   K           information word width, 1..57
//   M (derived) smallest value with 2**M >= M+K+1
//   N (derived) M+K; codeword width is N+1
//
// Ports (hamming_top):
//   clk_i        in   1    clock, rising edge
//   rst_ni       in   1    asynchronous active-low reset
//   d_i          in   K    information word to encode
//   err_mask_i   in   N+1  error-injection mask (HAMMING_ERR_INJ_EN only)
//   q_o          out  K    decoded / corrected information word
//   syndrome_o   out  M    raw Hamming syndrome
//   sb_err_o     out  1    single-bit error detected (any bit incl. cw[0])
//   db_err_o     out  1    uncorrectable (double / multi-bit) error
//   sb_fix_o     out  1    single-bit error corrected in a data position
// -----------------------------------------------------------------------------

package hamming_pkg;

  // Number of Hamming parity bits needed for a k-bit word.
  function automatic int calc_m(input int k);
    int m;
    m = 1;
    while ((1 << m) < (m + k + 1)) m++;
    return m;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Codeword position (1..n) that carries data bit i.
  function automatic int data_pos(input int i, input int n);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= n; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == i) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// -----------------------------------------------------------------------------
// hamming_dec -- decode stage. Combinational syndrome / correction logic on
// cw_i with all results registered.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   cw_i            (N+1)-bit codeword to check
//   q_o, syndrome_o, sb_err_o, db_err_o, sb_fix_o   as for hamming_top
// -----------------------------------------------------------------------------
module hamming_dec #(
  parameter  int K = 8,
  localparam int M = hamming_pkg::calc_m(K),
  localparam int N = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N:0]   cw_i,
  output logic [K-1:0] q_o,
  output logic [M-1:0] syndrome_o,
  output logic         sb_err_o,
  output logic         db_err_o,
  output logic         sb_fix_o
);

  localparam int IW = $clog2(N + 1);
  typedef logic [IW-1:0] idx_t;
  typedef logic [M-1:0]  syn_t;

  syn_t         syn;
  logic         par;
  logic [N:0]   flip;
  logic         hit_any;
  logic         hit_data;
  logic         do_fix;
  logic [N:0]   corr;
  logic [K-1:0] data_n;
  logic         sb_n;
  logic         db_n;
  logic         fix_n;

  // Syndrome: XOR of the indices of all set bits in cw[1..N].
  always_comb begin
    syn = '0;
    for (int p = 1; p <= N; p++) begin
      if (cw_i[idx_t'(p)]) syn = syn ^ syn_t'(p);
    end
  end

  assign par = ^cw_i;

  // One-hot pointer to the position named by the syndrome. Stays zero when
  // the syndrome is 0 or points beyond N, which is what separates the
  // correctable single-bit case from the out-of-range multi-bit case.
  always_comb begin
    flip     = '0;
    hit_data = 1'b0;
    for (int p = 1; p <= N; p++) begin
      if (syn == syn_t'(p)) begin
        flip[idx_t'(p)] = 1'b1;
        hit_data        = !hamming_pkg::is_pow2(p);
      end
    end
  end

  assign hit_any = |flip;

  // Only an odd overall parity makes the syndrome trustworthy as a position;
  // with even parity a nonzero syndrome means two flips and nothing is fixed.
  assign do_fix = par & hit_any;
  assign corr   = do_fix ? (cw_i ^ flip) : cw_i;

  assign sb_n  = par & ((syn == '0) | hit_any);
  assign db_n  = (syn != '0) & ~do_fix;
  assign fix_n = do_fix & hit_data;

  always_comb begin
    data_n = '0;
    for (int i = 0; i < K; i++) begin
      data_n[i] = corr[idx_t'(hamming_pkg::data_pos(i, N))];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o        <= '0;
      syndrome_o <= '0;
      sb_err_o   <= 1'b0;
      db_err_o   <= 1'b0;
      sb_fix_o   <= 1'b0;
    end else begin
      q_o        <= data_n;
      syndrome_o <= syn;
      sb_err_o   <= sb_n;
      db_err_o   <= db_n;
      sb_fix_o   <= fix_n;
    end
  end

endmodule

// -----------------------------------------------------------------------------
// hamming_top -- encode stage plus hamming_dec.
// -----------------------------------------------------------------------------
module hamming_top #(
  parameter  int K = 8,
  localparam int M = hamming_pkg::calc_m(K),
  localparam int N = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [K-1:0] d_i,
`ifdef HAMMING_ERR_INJ_EN
  input  logic [N:0]   err_mask_i,
`endif
  output logic [K-1:0] q_o,
  output logic [M-1:0] syndrome_o,
  output logic         sb_err_o,
  output logic         db_err_o,
  output logic         sb_fix_o
);

  localparam int IW = $clog2(N + 1);
  typedef logic [IW-1:0] idx_t;
  typedef logic [M-1:0]  syn_t;

  logic [N:0] placed;
  syn_t       s;
  logic [N:0] cw_enc;
  logic [N:0] mask;
  logic [N:0] cw_q;

`ifdef HAMMING_ERR_INJ_EN
  assign mask = err_mask_i;
`else
  assign mask = '0;
`endif

  // Data bits scattered into their non-power-of-two positions.
  always_comb begin
    placed = '0;
    for (int i = 0; i < K; i++) begin
      placed[idx_t'(hamming_pkg::data_pos(i, N))] = d_i[i];
    end
  end

  // Syndrome of the data-only word. Setting parity bit 2**j to bit j of this
  // value is exactly the even-parity rule and drives the full syndrome to 0.
  always_comb begin
    s = '0;
    for (int p = 1; p <= N; p++) begin
      if (placed[idx_t'(p)]) s = s ^ syn_t'(p);
    end
  end

  always_comb begin
    cw_enc = placed;
    for (int j = 0; j < M; j++) begin
      cw_enc[idx_t'(1 << j)] = ^(s & syn_t'(1 << j));
    end
    // Parity over cw[1..N] = data bits plus the parity bits just placed.
    cw_enc[0] = (^placed) ^ (^s);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cw_q <= '0;
    else         cw_q <= cw_enc ^ mask;
  end

  hamming_dec #(.K(K)) u_dec (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cw_i       (cw_q),
    .q_o        (q_o),
    .syndrome_o (syndrome_o),
    .sb_err_o   (sb_err_o),
    .db_err_o   (db_err_o),
    .sb_fix_o   (sb_fix_o)
  );

endmodule

// File: tb/tb_hamming_top.sv
module tb_hamming_top;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] syn;
    logic       sb;
    logic       db;
    logic       fix;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  d = '0;
  logic [7:0]  q;
  logic [3:0]  syn;
  logic        sb, db, fix;
`ifdef HAMMING_ERR_INJ_EN
  logic [12:0] mask = '0;
`endif

  logic [12:0] cw_t = '0;
  logic [7:0]  dq;
  logic [3:0]  dsyn;
  logic        dsb, ddb, dfix;

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];
  exp_t dexp_q[$];

  logic vin = 1'b0, v1, v2;
  logic dvin = 1'b0, dv1;

  always #5 clk = ~clk;

  hamming_top #(.K(8)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .d_i        (d),
`ifdef HAMMING_ERR_INJ_EN
    .err_mask_i (mask),
`endif
    .q_o        (q),
    .syndrome_o (syn),
    .sb_err_o   (sb),
    .db_err_o   (db),
    .sb_fix_o   (fix)
  );

  hamming_dec #(.K(8)) u_dec_only (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cw_i       (cw_t),
    .q_o        (dq),
    .syndrome_o (dsyn),
    .sb_err_o   (dsb),
    .db_err_o   (ddb),
    .sb_fix_o   (dfix)
  );

  function automatic exp_t mk(input logic [7:0] eq, input logic [3:0] es,
                              input logic esb, input logic edb, input logic efix);
    exp_t e;
    e.q = eq; e.syn = es; e.sb = esb; e.db = edb; e.fix = efix;
    return e;
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got q=%h syn=%b sb=%b db=%b fix=%b, expected q=%h syn=%b sb=%b db=%b fix=%b",
               nm, act.q, act.syn, act.sb, act.db, act.fix,
               req.q, req.syn, req.sb, req.db, req.fix);
    end
  endtask

  // Expected-valid pipelines track the DUT latency and are flushed by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; dv1 <= 1'b0;
    end else begin
      v1 <= vin; v2 <= v1; dv1 <= dvin;
    end
  end

  // Monitor: pops and compares whenever an output is due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v2) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL top_underflow: output present, expected queue empty");
        end else begin
          check("top", mk(q, syn, sb, db, fix), exp_q.pop_front());
        end
      end
      if (dv1) begin
        if (dexp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL dec_underflow: output present, expected queue empty");
        end else begin
          check("dec", mk(dq, dsyn, dsb, ddb, dfix), dexp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1: drives one word, returns at the next posedge+1.
  task automatic send(input logic [7:0] dv, input exp_t e);
    d   = dv;
    vin = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic send_dec(input logic [12:0] cw, input exp_t e);
    cw_t = cw;
    dvin = 1'b1;
    dexp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic check_cw(input string nm, input logic [12:0] req);
    tests++;
    if (u_dut.cw_q !== req) begin
      fails++;
      $display("FAIL %s: got cw=%h, expected cw=%h", nm, u_dut.cw_q, req);
    end
  endtask

  // Error masks applied to the d=0xAF codeword 0x14EB, with hand-derived results.
  localparam int NV = 9;
  logic [12:0] vmask [NV] = '{13'h0000, 13'h0008, 13'h0001, 13'h0028, 13'h0112,
                              13'h0002, 13'h1000, 13'h0010, 13'h0060};
  exp_t vexp [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vexp[0] = mk(8'hAF, 4'b0000, 1'b0, 1'b0, 1'b0);
    vexp[1] = mk(8'hAF, 4'b0011, 1'b1, 1'b0, 1'b1);
    vexp[2] = mk(8'hAF, 4'b0000, 1'b1, 1'b0, 1'b0);
    vexp[3] = mk(8'hAC, 4'b0110, 1'b0, 1'b1, 1'b0);
    vexp[4] = mk(8'hAF, 4'b1101, 1'b0, 1'b1, 1'b0);
    vexp[5] = mk(8'hAF, 4'b0001, 1'b1, 1'b0, 1'b0);
    vexp[6] = mk(8'hAF, 4'b1100, 1'b1, 1'b0, 1'b1);
    vexp[7] = mk(8'hAF, 4'b0100, 1'b1, 1'b0, 1'b0);
    vexp[8] = mk(8'hA9, 4'b0011, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", mk(q, syn, sb, db, fix), '0);
    rst_n = 1'b1;

    // Decode stage on hand-built codewords.
    for (int i = 0; i < NV; i++) send_dec(13'h14EB ^ vmask[i], vexp[i]);
    send_dec(13'h1EEE, mk(8'hFF, 4'b0000, 1'b0, 1'b0, 1'b0));
    send_dec(13'h0000, mk(8'h00, 4'b0000, 1'b0, 1'b0, 1'b0));
    dvin = 1'b0;

`ifdef HAMMING_ERR_INJ_EN
    for (int i = 0; i < NV; i++) begin
      mask = vmask[i];
      send(8'hAF, vexp[i]);
    end
    mask = '0;
`endif

    // Back-to-back stream with a reset pulse in the middle.
    for (int i = 0; i < 256; i++) begin
      send(8'(i), mk(8'(i), 4'b0000, 1'b0, 1'b0, 1'b0));
      if (i == 8'hAF) check_cw("enc_0xAF", 13'h14EB);
      if (i == 8'hFF) check_cw("enc_0xFF", 13'h1EEE);
      if (i == 100) begin
        @(negedge clk); #2;
        rst_n = 1'b0;
        vin   = 1'b0;
        #1;
        check("reset_async", mk(q, syn, sb, db, fix), '0);
        check_cw("reset_cw", 13'h0000);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", mk(q, syn, sb, db, fix), '0);
        rst_n = 1'b1;
      end
    end
    vin = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0 || dexp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_q.size(), dexp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hamming_top.md
HAMMING_TOP -- requirements
Module: hamming_top

Interface
REQ-001 Parameter K, default 8, information word width in bits; legal range 1..57.
REQ-002 Derived localparam M: smallest integer with 2**M >= M+K+1 (K=8 -> M=4); N = M+K (K=8 -> 12); codeword width N+1.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous and active-low.
REQ-005 d_i  input  K  information word to encode.
REQ-006 err_mask_i  input  N+1  error-injection mask XORed onto codeword; present only with HAMMING_ERR_INJ_EN.
REQ-007 q_o  output  K  decoded (corrected where possible) information word.
REQ-008 syndrome_o  output  M  Hamming syndrome of received codeword.
REQ-009 sb_err_o  output  1  single-bit error detected (any codeword bit, including overall parity).
REQ-010 db_err_o  output  1  uncorrectable (double or detected multi-bit) error.
REQ-011 sb_fix_o  output  1  single-bit error corrected in a data-carrying position.

Function
REQ-012 Codeword bits cw[1..N] are Hamming positions; parity bits at positions 1,2,4,..,2**(M-1); data d_i[0..K-1] occupy remaining positions in ascending order.
REQ-013 Parity bit at position 2**j is even parity over all positions whose index has bit j set; cw[0] is even parity over cw[1..N].
REQ-014 Stage 1 (encode) registers cw XOR err_mask_i on each rising edge.
REQ-015 Stage 2 (decode) computes from the registered codeword and registers all outputs; total latency d_i -> outputs is exactly 2 cycles, fully pipelined, new word every cycle.
REQ-016 Syndrome = XOR of indices of all set bits in cw[1..N]; overall check P = XOR of cw[0..N].
REQ-017 Syndrome==0, P==0: no error; q_o = extracted data; all flags 0.
REQ-018 Syndrome==0, P==1: error in cw[0]; sb_err_o=1, sb_fix_o=0, db_err_o=0, q_o = extracted data.
REQ-019 Syndrome in 1..N, P==1: flip position syndrome; sb_err_o=1; sb_fix_o=1 only if the position carries data, else 0; db_err_o=0.
REQ-020 Syndrome > N, P==1: db_err_o=1, sb_err_o=0, sb_fix_o=0, q_o = uncorrected data.
REQ-021 Syndrome !=0, P==0: db_err_o=1, sb_err_o=0, sb_fix_o=0, q_o = uncorrected data.
REQ-022 sb_err_o and db_err_o never both 1; syndrome_o always reports the raw syndrome.

Reset
REQ-023 rst_ni low asynchronously clears stage-1 codeword and all outputs (q_o, syndrome_o, flags) to 0.
REQ-024 First valid outputs appear 2 rising edges after rst_ni deasserts with stable d_i; reset mid-stream discards in-flight words.

Configuration
REQ-025 Macro HAMMING_ERR_INJ_EN defined: err_mask_i port exists and is applied per REQ-014.
REQ-026 Macro undefined: err_mask_i port absent, mask treated as all-zero; outputs then always report no error.

Verification
REQ-027 K=8, d_i=0xAF, mask 0x0000 -> after 2 cycles q_o=0xAF, syndrome_o=0000, all flags 0 (stage-1 cw=0x14EB).
REQ-028 d_i=0xAF, mask 0x0008 -> q_o=0xAF, syndrome_o=0011, sb_err_o=1, sb_fix_o=1, db_err_o=0.
REQ-029 d_i=0xAF, mask 0x0001 -> q_o=0xAF, syndrome_o=0000, sb_err_o=1, sb_fix_o=0, db_err_o=0.
REQ-030 d_i=0xAF, mask 0x0028 -> q_o=0xAC, syndrome_o=0110, db_err_o=1, sb_err_o=0, sb_fix_o=0.
REQ-031 d_i=0xAF, mask 0x0112 -> syndrome_o=1101 (>N), db_err_o=1, q_o=0xAF.
REQ-032 Stream 0x00..0xFF back-to-back, rst_ni pulsed low mid-stream -> outputs 0 immediately, then correct data 2 cycles after release.
